// File: rtl/jrb8_pkg.sv
// ---------------------------------------------------------------------------
// jrb8_pkg
// Shared definitions for the jrb8 memory arbiter: FSM state encoding,
// requester indices and the data width of the memory port.
// ---------------------------------------------------------------------------
package jrb8_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_t;

    // Requester indices; bit positions in the request/grant vectors.
    localparam logic [1:0] REQ_F = 2'd0;
    localparam logic [1:0] REQ_D = 2'd1;
    localparam logic [1:0] REQ_X = 2'd2;

    // Convert a one-hot grant vector to a requester index (fetch when empty).
    function automatic logic [1:0] onehot_to_idx(input logic [2:0] oh);
        logic [1:0] idx;
        idx = REQ_F;
        if (oh[REQ_X])      idx = REQ_X;
        else if (oh[REQ_D]) idx = REQ_D;
        return idx;
    endfunction

endpackage

// File: rtl/mem_arbiter_prio_pick.sv
// ---------------------------------------------------------------------------
// prio_pick
// Combinational 3-input fixed-priority selector (bit 2 > bit 1 > bit 0).
// Ports:
//   req   [2:0]  raw request vector, indexed by requester
//   mask  [2:0]  requests to ignore for this arbitration
//   grant [2:0]  one-hot winner (all zero when nothing eligible)
//   valid        at least one eligible request
// ---------------------------------------------------------------------------
module prio_pick
    import jrb8_pkg::*;
(
    input  logic [2:0] req,
    input  logic [2:0] mask,
    output logic [2:0] grant,
    output logic       valid
);

    logic [2:0] eligible;

    assign eligible = req & ~mask;
    assign valid    = |eligible;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        grant = '0;
        if (eligible[REQ_X])      grant[REQ_X] = 1'b1;
        else if (eligible[REQ_D]) grant[REQ_D] = 1'b1;
        else if (eligible[REQ_F]) grant[REQ_F] = 1'b1;
    end

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares one 8-bit memory port among instruction fetch (f), data path (d)
// and the external program-load/debug port (x). Each access is a
// multi-cycle IDLE -> ACCESS -> RESP transaction with programmable wait
// states and a mem_ready qualifier on the final wait cycle.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   f_req/f_addr                    fetch read request
//   d_req/d_we/d_addr/d_wdata       data-path request
//   x_req/x_we/x_addr/x_wdata       external-port request
//   f_ack/d_ack/x_ack               one-cycle completion pulses
//   rdata                           read data, valid with any ack
//   x_hold                          external port owns (or is claiming) the bus
//   busy                            FSM not in IDLE
//   mem_en/mem_we/mem_addr/mem_wdata memory port outputs
//   mem_rdata/mem_ready             memory read data and completion qualifier
// ---------------------------------------------------------------------------
module mem_arbiter
    import jrb8_pkg::*;
#(
    parameter int ADDR_W       = 16,
    parameter int WAIT_CYCLES  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic              x_req,
    input  logic              x_we,
    input  logic [ADDR_W-1:0] x_addr,
    input  logic [DATA_W-1:0] x_wdata,
    output logic              f_ack,
    output logic              d_ack,
    output logic              x_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              x_hold,
    output logic              busy,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);
    localparam logic [3:0] XCNT_MAX  = 4'(STARVE_LIMIT);

    state_t            state, state_nx;
    logic [1:0]        idx_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [3:0]        wcnt_q;
    logic [3:0]        xcnt_q;

    logic [2:0] req_vec;
    logic [2:0] mask;
    logic [2:0] grant;
    logic       grant_valid;
    logic [1:0] grant_idx;
    logic       last_wait;
    logic       access_done;

    assign req_vec = {x_req, d_req, f_req};

    // After STARVE_LIMIT back-to-back external grants, the CPU gets the next
    // slot if it is asking; otherwise x keeps winning.
    assign mask = {(xcnt_q == XCNT_MAX) && (d_req || f_req), 2'b00};

    prio_pick u_pick (
        .req   (req_vec),
        .mask  (mask),
        .grant (grant),
        .valid (grant_valid)
    );

    assign grant_idx   = onehot_to_idx(grant);
    assign last_wait   = (wcnt_q == WAIT_LAST);
    assign access_done = last_wait && mem_ready;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (grant_valid) state_nx = ACCESS;
            ACCESS:  if (access_done) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= REQ_F;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            wcnt_q  <= '0;
            xcnt_q  <= '0;
        end else begin
            if (state == IDLE && grant_valid) begin
                idx_q  <= grant_idx;
                wcnt_q <= '0;
                case (grant_idx)
                    REQ_X: begin
                        we_q    <= x_we;
                        addr_q  <= x_addr;
                        wdata_q <= x_wdata;
                        if (xcnt_q != XCNT_MAX) xcnt_q <= xcnt_q + 4'd1;
                    end
                    REQ_D: begin
                        we_q    <= d_we;
                        addr_q  <= d_addr;
                        wdata_q <= d_wdata;
                        xcnt_q  <= '0;
                    end
                    default: begin
                        // Fetch is read-only.
                        we_q    <= 1'b0;
                        addr_q  <= f_addr;
                        wdata_q <= '0;
                        xcnt_q  <= '0;
                    end
                endcase
            end
            if (state == ACCESS) begin
                // Held at the final count while the memory is not ready.
                if (!last_wait)  wcnt_q  <= wcnt_q + 4'd1;
                if (access_done) rdata_q <= mem_rdata;
            end
        end
    end

    // Strobes decode from the async-reset state register, so they drop the
    // moment rst_n falls.
    assign mem_en    = (state == ACCESS);
    assign mem_we    = (state == ACCESS) && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rdata     = rdata_q;
    assign busy      = (state != IDLE);
    assign f_ack     = (state == RESP) && (idx_q == REQ_F);
    assign d_ack     = (state == RESP) && (idx_q == REQ_D);
    assign x_ack     = (state == RESP) && (idx_q == REQ_X);

    // In IDLE x_hold follows x_req directly so the CPU sequencer stalls in
    // the same cycle the external port claims the bus.
    assign x_hold = (state == IDLE) ? x_req : (idx_q == REQ_X);

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter. Requesters are modelled as counts of
// outstanding accesses with their current address/we/wdata; the expected
// winner of every arbitration, the ACCESS length, the bus contents and the
// ack/rdata of each transaction are computed from the arbitration rules.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int ADDR_W       = 16;
    localparam int WAIT_CYCLES  = 2;
    localparam int STARVE_LIMIT = 4;
    localparam int F = 0;
    localparam int D = 1;
    localparam int X = 2;

    logic              clk;
    logic              rst_n;
    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [7:0]        d_wdata;
    logic              x_req;
    logic              x_we;
    logic [ADDR_W-1:0] x_addr;
    logic [7:0]        x_wdata;
    logic              f_ack;
    logic              d_ack;
    logic              x_ack;
    logic [7:0]        rdata;
    logic              x_hold;
    logic              busy;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;
    logic              mem_ready;

    mem_arbiter #(
        .ADDR_W       (ADDR_W),
        .WAIT_CYCLES  (WAIT_CYCLES),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .f_req     (f_req),
        .f_addr    (f_addr),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .x_req     (x_req),
        .x_we      (x_we),
        .x_addr    (x_addr),
        .x_wdata   (x_wdata),
        .f_ack     (f_ack),
        .d_ack     (d_ack),
        .x_ack     (x_ack),
        .rdata     (rdata),
        .x_hold    (x_hold),
        .busy      (busy),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: outstanding accesses and current fields per requester.
    int          rem [3];
    logic [15:0] a   [3];
    logic        we_m[3];
    logic [7:0]  wd  [3];
    int          xc;            // consecutive external grants

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic new_fields(input int r);
        a[r]    = 16'($urandom_range(0, 65535));
        we_m[r] = 1'($urandom_range(0, 1));
        wd[r]   = 8'($urandom_range(0, 255));
    endtask

    task automatic drive();
        f_req   = (rem[F] > 0);
        f_addr  = a[F];
        d_req   = (rem[D] > 0);
        d_we    = we_m[D];
        d_addr  = a[D];
        d_wdata = wd[D];
        x_req   = (rem[X] > 0);
        x_we    = we_m[X];
        x_addr  = a[X];
        x_wdata = wd[X];
    endtask

    // Winner under x > d > f, with x skipped once it has won STARVE_LIMIT
    // times in a row while the CPU is waiting.
    function automatic int pick();
        bit cpu_waiting;
        cpu_waiting = (rem[F] > 0) || (rem[D] > 0);
        if (rem[X] > 0 && !(xc == STARVE_LIMIT && cpu_waiting)) return X;
        if (rem[D] > 0) return D;
        if (rem[F] > 0) return F;
        return -1;
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, ".acks"},      {29'd0, x_ack, d_ack, f_ack}, 32'd0);
        check({tag, ".mem_en"},    32'(mem_en),    32'd0);
        check({tag, ".mem_we"},    32'(mem_we),    32'd0);
        check({tag, ".mem_addr"},  32'(mem_addr),  32'd0);
        check({tag, ".mem_wdata"}, 32'(mem_wdata), 32'd0);
        check({tag, ".rdata"},     32'(rdata),     32'd0);
        check({tag, ".x_hold"},    32'(x_hold),    32'd0);
        check({tag, ".busy"},      32'(busy),      32'd0);
    endtask

    // Runs one transaction. Entered at the falling edge of an IDLE cycle with
    // requests already driven; returns at the falling edge of the next IDLE
    // cycle. stall = cycles mem_ready is held low at the final wait count.
    task automatic serve(input int stall, input logic [7:0] rd);
        int          w;
        logic [15:0] ea;
        logic        ewe;
        logic [7:0]  ewd;
        int          n_acc;
        w = pick();
        if (w < 0) begin
            check("no_request", 32'd1, 32'd0);
            return;
        end
        ea    = a[w];
        ewe   = (w != F) && we_m[w];
        ewd   = wd[w];
        n_acc = WAIT_CYCLES + stall;
        xc    = (w == X) ? ((xc < STARVE_LIMIT) ? xc + 1 : xc) : 0;

        @(posedge clk);  // arbitration edge
        for (int c = 1; c <= n_acc; c++) begin
            @(negedge clk);
            // Before the final count mem_ready is irrelevant, so randomise it.
            if (c < WAIT_CYCLES) mem_ready = 1'($urandom_range(0, 1));
            else                 mem_ready = (c >= n_acc);
            mem_rdata = (c == n_acc) ? rd : 8'($urandom_range(0, 255));
            check("acc.mem_en",   32'(mem_en),   32'd1);
            check("acc.mem_addr", 32'(mem_addr), 32'(ea));
            check("acc.mem_we",   32'(mem_we),   32'(ewe));
            if (ewe) check("acc.mem_wdata", 32'(mem_wdata), 32'(ewd));
            check("acc.acks",     {29'd0, x_ack, d_ack, f_ack}, 32'd0);
            check("acc.x_hold",   32'(x_hold),   32'(w == X));
            check("acc.busy",     32'(busy),     32'd1);
            // The winner may already present its next access; the arbiter
            // must keep using the latched copy.
            if (c == 1 && rem[w] > 1) begin
                new_fields(w);
                drive();
            end
        end

        @(negedge clk);  // RESP cycle
        mem_rdata = 8'($urandom_range(0, 255));
        mem_ready = 1'($urandom_range(0, 1));
        check("resp.acks",   {29'd0, x_ack, d_ack, f_ack}, 32'(1 << w));
        check("resp.rdata",  32'(rdata),  32'(rd));
        check("resp.mem_en", 32'(mem_en), 32'd0);
        check("resp.x_hold", 32'(x_hold), 32'(w == X));
        rem[w]--;
        drive();

        @(negedge clk);  // following IDLE cycle
        check("idle.busy",   32'(busy),   32'd0);
        check("idle.mem_en", 32'(mem_en), 32'd0);
        check("idle.acks",   {29'd0, x_ack, d_ack, f_ack}, 32'd0);
        check("idle.x_hold", 32'(x_hold), 32'(rem[X] > 0));
    endtask

    // stall < 0 or rd < 0 selects a random value per transaction.
    task automatic run_round(input int stall, input int rd);
        drive();
        while (rem[F] + rem[D] + rem[X] > 0) begin
            serve((stall < 0) ? int'($urandom_range(0, 2)) : stall,
                  (rd < 0) ? 8'($urandom_range(0, 255)) : 8'(rd));
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 8'h00;
        xc        = 0;
        for (int i = 0; i < 3; i++) begin
            rem[i] = 0; a[i] = '0; we_m[i] = 1'b0; wd[i] = '0;
        end
        drive();

        #12;
        check_reset_vals("in_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_vals("after_reset");

        // Single fetch of 0x0010 returning 0xA5.
        rem[F] = 1;
        a[F]   = 16'h0010;
        run_round(0, 'hA5);

        // Collision: x, d (write 0x3C to 0x0200) and f in the same cycle.
        rem[F] = 1; new_fields(F);
        rem[D] = 1; a[D] = 16'h0200; we_m[D] = 1'b1; wd[D] = 8'h3C;
        rem[X] = 1; new_fields(X);
        run_round(0, -1);

        // Starvation: x held for 8 accesses while d waits for one.
        rem[X] = 8; new_fields(X);
        rem[D] = 1; new_fields(D);
        run_round(0, -1);

        // Wait extension: memory not ready for 3 cycles at the final count.
        rem[D] = 1; new_fields(D);
        run_round(3, -1);
        rem[X] = 1; new_fields(X);
        run_round(1, -1);

        // Random mixes of outstanding work with random stalls.
        repeat (25) begin
            for (int i = 0; i < 3; i++) begin
                rem[i] = $urandom_range(0, 3);
                new_fields(i);
            end
            run_round(-1, -1);
        end

        // Async reset in the middle of an external write.
        rem[X] = 1; a[X] = 16'h1234; we_m[X] = 1'b1; wd[X] = 8'h77;
        drive();
        @(posedge clk);
        @(negedge clk);
        check("pre_rst.mem_en", 32'(mem_en), 32'd1);
        check("pre_rst.mem_we", 32'(mem_we), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async.mem_en", 32'(mem_en), 32'd0);
        check("async.mem_we", 32'(mem_we), 32'd0);
        rem[X] = 0;
        xc     = 0;
        drive();
        @(posedge clk);
        @(negedge clk);
        check_reset_vals("held_reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_vals("released");
        @(negedge clk);
        check_reset_vals("released2");

        // Normal operation resumes after reset.
        rem[F] = 1; new_fields(F);
        rem[X] = 2; new_fields(X);
        run_round(0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
